lc3_mem_responder: RTL

- Memory-side responder for the LC-3 core's MAR/MDR/memwe bus: word-addressed RAM plus memory-mapped keyboard and display registers.
- Reads are combinational (memOut follows mar), so the core's MDR captures data one cycle after it loads MAR.
- Writes commit on the clock edge where memwe=1.
- Keyboard input and display output cross to external agents through valid/ready handshakes.

---
 rtl/lc3_mem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: word RAM plus keyboard/display MMIO registers with valid/ready handshakes.
// Optional keyboard interrupt enable (KBSR[14]) and kbd_irq are built only with LC3_MMIO_KBD_IE_EN.
module lc3_mem_responder #(
  parameter int unsigned ADDR_BITS = 12,
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  input  logic        memwe,
  output logic [15:0] memOut,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready,
  output logic        kbd_irq
);

  localparam int unsigned RAM_DEPTH = 32'd1 << ADDR_BITS;

  logic [15:0] ram [RAM_DEPTH];

  logic        kbsr_ready;
  logic        kbsr_ie;
  logic [7:0]  kbdr;
  logic        dsr_ready;
  logic [15:0] mar_prev;

  logic        is_kbsr;
  logic        is_kbdr;
  logic        is_dsr;
  logic        is_ddr;
  logic        is_io;
  logic        in_ram;
  logic        kbd_accept;
  logic        kbdr_clear;
  logic        ddr_write;
  logic        disp_done;

  function automatic logic addr_in_ram(input logic [15:0] a);
    return {16'b0, a} < RAM_DEPTH;
  endfunction

  always_comb begin
    is_kbsr    = (mar == KBSR_ADDR);
    is_kbdr    = (mar == KBDR_ADDR);
    is_dsr     = (mar == DSR_ADDR);
    is_ddr     = (mar == DDR_ADDR);
    is_io      = is_kbsr | is_kbdr | is_dsr | is_ddr;
    in_ram     = addr_in_ram(mar);
    kbd_ready  = ~kbsr_ready;
    kbd_accept = kbd_valid & ~kbsr_ready;
    // Read-clear fires only on the cycle mar first lands on KBDR, not while it dwells there.
    kbdr_clear = is_kbdr & (mar_prev != KBDR_ADDR);
    ddr_write  = memwe & is_ddr & dsr_ready;
    disp_done  = disp_valid & disp_ready;
  end

  // IO decode has priority so RAM configurations that reach 0xFE00 stay shadowed.
  always_comb begin
    memOut = 16'h0000;
    if (is_kbsr)
      memOut = {kbsr_ready, kbsr_ie, 14'b0};
    else if (is_kbdr)
      memOut = {8'b0, kbdr};
    else if (is_dsr)
      memOut = {dsr_ready, 15'b0};
    else if (is_ddr)
      memOut = 16'h0000;
    else if (in_ram)
      memOut = ram[mar[ADDR_BITS-1:0]];
  end

  always_ff @(posedge clk) begin
    if (memwe && in_ram && !is_io)
      ram[mar[ADDR_BITS-1:0]] <= mdr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbsr_ready <= 1'b0;
      kbdr       <= 8'h00;
      mar_prev   <= 16'h0000;
    end else begin
      mar_prev <= mar;
      // Accept needs kbsr_ready=0, so it never collides with a meaningful clear.
      if (kbd_accept) begin
        kbdr       <= kbd_data;
        kbsr_ready <= 1'b1;
      end else if (kbdr_clear) begin
        kbsr_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsr_ready  <= 1'b1;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
    end else begin
      // dsr_ready is low whenever disp_valid is high, so a DDR write during the handshake is dropped.
      if (disp_done) begin
        disp_valid <= 1'b0;
        dsr_ready  <= 1'b1;
      end else if (ddr_write) begin
        disp_data  <= mdr[7:0];
        disp_valid <= 1'b1;
        dsr_ready  <= 1'b0;
      end
    end
  end

`ifdef LC3_MMIO_KBD_IE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      kbsr_ie <= 1'b0;
    else if (memwe && is_kbsr)
      kbsr_ie <= mdr[14];
  end

  assign kbd_irq = kbsr_ready & kbsr_ie;
`else
  assign kbsr_ie = 1'b0;
  assign kbd_irq = 1'b0;
`endif

endmodule
